// File: rtl/seg_display_scan.sv
// Time-multiplexed 6-digit common-anode 7-segment scanner for an HH:MM:SS clock.
// Optional colon blinking on tick_1hz is enabled by defining COLON_BLINK_EN.
module seg_display_scan #(
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       en,
    input  logic       tick_1hz,
    input  logic [3:0] sec_ones,
    input  logic [2:0] sec_tens,
    input  logic [3:0] min_ones,
    input  logic [2:0] min_tens,
    input  logic [3:0] hr_ones,
    input  logic [1:0] hr_tens,
    output logic [5:0] anode,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GUARD_C = CW'(GUARD);

    logic [CW-1:0] cnt_reg, cnt_next;
    logic [2:0]    idx_reg, idx_next;
    logic [3:0]    snap_reg [6];
    logic [3:0]    digit_in [6];
    logic          frame_wrap;
    logic [5:0]    slot_sel;
    logic          colon_slot;
    logic          in_guard;
    logic          colon_dp;

    logic [5:0]    anode_reg, anode_next;
    logic [6:0]    seg_reg, seg_next;
    logic          dp_reg, dp_next;

    // Narrower tens digits are zero-extended so every slot decodes the same way.
    assign digit_in[0] = sec_ones;
    assign digit_in[1] = {1'b0, sec_tens};
    assign digit_in[2] = min_ones;
    assign digit_in[3] = {1'b0, min_tens};
    assign digit_in[4] = hr_ones;
    assign digit_in[5] = {2'b00, hr_tens};

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_slot
            assign slot_sel[gi] = (idx_reg == 3'(gi));
        end
    endgenerate

    assign colon_slot = slot_sel[2] | slot_sel[4];
    assign in_guard   = (cnt_reg < GUARD_C);
    assign frame_wrap = en && (cnt_reg == CNT_MAX) && (idx_reg == 3'd5);

`ifdef COLON_BLINK_EN
    logic blink_reg;

    // Blink follows the 1 Hz tick even while scanning is paused.
    always_ff @(posedge clk) begin
        if (rstn) begin
            blink_reg <= 1'b1;
        end else if (tick_1hz) begin
            blink_reg <= ~blink_reg;
        end
    end

    assign colon_dp = ~blink_reg;
`else
    logic unused_tick;

    assign unused_tick = tick_1hz;
    assign colon_dp    = 1'b0;
`endif

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    always_comb begin
        cnt_next = cnt_reg;
        idx_next = idx_reg;
        if (en) begin
            if (cnt_reg == CNT_MAX) begin
                cnt_next = '0;
                idx_next = (idx_reg == 3'd5) ? 3'd0 : idx_reg + 3'd1;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    // Output image for the slot/count/snapshot held before this edge.
    always_comb begin
        anode_next = 6'h3F;
        seg_next   = 7'h7F;
        dp_next    = 1'b1;
        if (en) begin
            seg_next = decode(snap_reg[idx_reg]);
            if (!in_guard) begin
                anode_next = ~slot_sel;
                if (colon_slot) begin
                    dp_next = colon_dp;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            cnt_reg   <= '0;
            idx_reg   <= '0;
            anode_reg <= 6'h3F;
            seg_reg   <= 7'h7F;
            dp_reg    <= 1'b1;
            for (int i = 0; i < 6; i++) begin
                snap_reg[i] <= '0;
            end
        end else begin
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            anode_reg <= anode_next;
            seg_reg   <= seg_next;
            dp_reg    <= dp_next;
            // Capture the whole time at once so a frame never shows a torn value.
            if (frame_wrap) begin
                for (int i = 0; i < 6; i++) begin
                    snap_reg[i] <= digit_in[i];
                end
            end
        end
    end

    assign anode = anode_reg;
    assign seg   = seg_reg;
    assign dp    = dp_reg;

endmodule

// File: tb/tb_seg_display_scan.sv
// Scoreboard bench for seg_display_scan (REFRESH_DIV=4, GUARD=1); expected
// outputs are queued before each edge and compared one cycle later.
module tb_seg_display_scan;

    localparam int RD = 4;
    localparam int GD = 1;

    logic       clk = 1'b0;
    logic       rstn, en, tick_1hz;
    logic [3:0] sec_ones, min_ones, hr_ones;
    logic [2:0] sec_tens, min_tens;
    logic [1:0] hr_tens;
    logic [5:0] anode;
    logic [6:0] seg;
    logic       dp;

    typedef struct packed {
        logic [5:0] a;
        logic [6:0] s;
        logic       d;
    } out_t;

    out_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   ncyc = 0;
    int   m_cnt, m_idx, m_blink;
    int   m_snap[6];
    int   shown_idx = -1;
    int   shown_cnt = -1;

    seg_display_scan #(.REFRESH_DIV(RD), .GUARD(GD)) dut (
        .clk(clk), .rstn(rstn), .en(en), .tick_1hz(tick_1hz),
        .sec_ones(sec_ones), .sec_tens(sec_tens),
        .min_ones(min_ones), .min_tens(min_tens),
        .hr_ones(hr_ones), .hr_tens(hr_tens),
        .anode(anode), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, ncyc);
        end
    endtask

    function automatic logic [6:0] seg_of(input int v);
        logic [6:0] t;
        case (v)
            0: t = 7'b1000000;
            1: t = 7'b1111001;
            2: t = 7'b0100100;
            3: t = 7'b0110000;
            4: t = 7'b0011001;
            5: t = 7'b0010010;
            6: t = 7'b0000010;
            7: t = 7'b1111000;
            8: t = 7'b0000000;
            9: t = 7'b0010000;
            default: t = 7'b1111111;
        endcase
        return t;
    endfunction

    // One clock: predict, push, advance model, clock, pop and compare.
    task automatic cycle();
        out_t e;
        int   din[6];
        logic colon;
        din[0] = int'(sec_ones); din[1] = int'(sec_tens);
        din[2] = int'(min_ones); din[3] = int'(min_tens);
        din[4] = int'(hr_ones);  din[5] = int'(hr_tens);
`ifdef COLON_BLINK_EN
        colon = (m_blink == 0);
`else
        colon = 1'b0;
`endif
        e.a = 6'h3F; e.s = 7'h7F; e.d = 1'b1;
        if (!rstn && en) begin
            e.s = seg_of(m_snap[m_idx]);
            if (m_cnt >= GD) begin
                e.a = 6'h3F ^ (6'h01 << m_idx);
                if (m_idx == 2 || m_idx == 4) e.d = colon;
            end
        end
        exp_q.push_back(e);
        if (rstn) begin
            m_cnt = 0; m_idx = 0; m_blink = 1;
            for (int i = 0; i < 6; i++) m_snap[i] = 0;
        end else begin
            if (tick_1hz) m_blink = 1 - m_blink;
            if (en) begin
                shown_idx = m_idx;
                shown_cnt = m_cnt;
                if (m_cnt == RD - 1) begin
                    if (m_idx == 5) m_snap = din;
                    m_cnt = 0;
                    m_idx = (m_idx == 5) ? 0 : m_idx + 1;
                end else begin
                    m_cnt++;
                end
            end
        end
        @(posedge clk);
        #1;
        ncyc++;
        e = exp_q.pop_front();
        check_val("sb_anode", 32'(anode), 32'(e.a));
        check_val("sb_seg", 32'(seg), 32'(e.s));
        check_val("sb_dp", 32'(dp), 32'(e.d));
        $display("cyc %0d rst=%0b en=%0b anode=%h seg=%h dp=%0b", ncyc, rstn, en, anode, seg, dp);
    endtask

    // Clock until the output just produced shows slot s at count c.
    task automatic run_to(input int s, input int c);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (!(shown_idx == s && shown_cnt == c) && n < 64);
        if (!(shown_idx == s && shown_cnt == c))
            check_val("run_to_timeout", 32'(shown_idx * 16 + shown_cnt), 32'(s * 16 + c));
    endtask

    task automatic expect_out(input string tag, input logic [5:0] a, input logic [6:0] s, input logic d);
        check_val({tag, "_anode"}, 32'(anode), 32'(a));
        check_val({tag, "_seg"}, 32'(seg), 32'(s));
        check_val({tag, "_dp"}, 32'(dp), 32'(d));
    endtask

    initial begin
        logic colon_after;
        rstn = 1'b1; en = 1'b1; tick_1hz = 1'b0;
        sec_ones = 4'd0; sec_tens = 3'd0; min_ones = 4'd0;
        min_tens = 3'd0; hr_ones = 4'd0; hr_tens = 2'd0;
        m_cnt = 0; m_idx = 0; m_blink = 1;
        for (int i = 0; i < 6; i++) m_snap[i] = 0;

        // Reset for two cycles with en high: reset wins.
        cycle();
        cycle();
        expect_out("reset", 6'h3F, 7'h7F, 1'b1);

        // 12:34:56 applied; first frame still shows the zero snapshot.
        rstn = 1'b0;
        sec_ones = 4'd6; sec_tens = 3'd5; min_ones = 4'd4;
        min_tens = 3'd3; hr_ones = 4'd2; hr_tens = 2'd1;
        run_to(0, 0); expect_out("f1_s0_guard", 6'h3F, 7'h40, 1'b1);
        run_to(0, 1); expect_out("f1_s0", 6'h3E, 7'h40, 1'b1);
        run_to(5, 3); expect_out("f1_s5", 6'h1F, 7'h40, 1'b1);

        // Second frame shows the captured time.
        run_to(0, 0); expect_out("f2_s0_guard", 6'h3F, 7'h02, 1'b1);
        run_to(0, 1); expect_out("f2_s0", 6'h3E, 7'h02, 1'b1);
        run_to(1, 1); expect_out("f2_s1", 6'h3D, 7'h12, 1'b1);
        run_to(2, 1); expect_out("f2_s2", 6'h3B, 7'h19, 1'b0);
        run_to(3, 3); expect_out("f2_s3", 6'h37, 7'h30, 1'b1);
        run_to(5, 0); expect_out("f2_s5_guard", 6'h3F, 7'h79, 1'b1);
        run_to(5, 1); expect_out("f2_s5", 6'h1F, 7'h79, 1'b1);

        // Mid-frame input change waits for the next wrap.
        run_to(0, 1);
        sec_ones = 4'd7;
        run_to(0, 2); expect_out("midchg_old", 6'h3E, 7'h02, 1'b1);
        run_to(0, 1); expect_out("midchg_new", 6'h3E, 7'h78, 1'b1);

        // Pause mid-slot, then resume with the remaining count of slot 0.
        en = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        expect_out("paused", 6'h3F, 7'h7F, 1'b1);
        en = 1'b1;
        cycle(); expect_out("resume_c2", 6'h3E, 7'h78, 1'b1);
        cycle(); expect_out("resume_c3", 6'h3E, 7'h78, 1'b1);
        cycle(); expect_out("resume_s1_guard", 6'h3F, 7'h12, 1'b1);

        // Out-of-range digit blanks its slot.
        hr_ones = 4'hA;
        run_to(5, 3);
        run_to(4, 1); expect_out("blank_digit", 6'h2F, 7'h7F, 1'b0);

        // Colon dot behaviour across two tick pulses.
`ifdef COLON_BLINK_EN
        colon_after = 1'b1;
`else
        colon_after = 1'b0;
`endif
        tick_1hz = 1'b1; cycle(); tick_1hz = 1'b0;
        run_to(5, 3);
        run_to(2, 1); expect_out("tick1_s2", 6'h3B, 7'h19, colon_after);
        run_to(4, 2); check_val("tick1_s4_dp", 32'(dp), 32'(colon_after));
        tick_1hz = 1'b1; cycle(); tick_1hz = 1'b0;
        run_to(5, 3);
        run_to(2, 1); expect_out("tick2_s2", 6'h3B, 7'h19, 1'b0);

        // Reset mid-frame drops the snapshot and restarts at slot 0.
        run_to(3, 2);
        rstn = 1'b1; cycle(); expect_out("midrst", 6'h3F, 7'h7F, 1'b1);
        rstn = 1'b0;
        run_to(0, 1); expect_out("post_rst_s0", 6'h3E, 7'h40, 1'b1);
        run_to(2, 2); expect_out("post_rst_s2", 6'h3B, 7'h40, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
